// File: rtl/sdram_arbiter.sv
// sdram_arbiter: refresh-first, round-robin write/read scheduler for a single SDRAM command executor
//   clk, rst_n                  clock; asynchronous active-low reset
//   init_done                   executor power-up init complete (level)
//   wr_req, wr_addr, wr_ack     write port: held request, burst address, one-cycle grant
//   rd_req, rd_addr, rd_ack     read port: held request, burst address, one-cycle grant
//   cmd_valid, cmd_op, cmd_addr one-cycle start pulse to executor (op 01 ref, 10 write, 11 read)
//   exec_done                   executor finished the current operation
//   busy                        an operation is in flight
//   ref_overrun                 sticky: a refresh period expired with the previous refresh still pending
module sdram_arbiter #(
  parameter int ADDR_W     = 22,
  parameter int REF_PERIOD = 1562
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              cmd_valid,
  output logic [1:0]        cmd_op,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic              exec_done,
  output logic              busy,
  output logic              ref_overrun
);
  typedef enum logic [2:0] {S_WAIT_INIT, S_IDLE, S_REF, S_WR, S_RD} state_t;
  localparam logic [10:0] RELOAD = 11'(REF_PERIOD - 1);
  state_t state, state_nxt;
  logic [10:0] cnt;
  logic ref_pending, last_rd, run, expire, idle_free, issue_ref, gnt_wr, gnt_rd;
  // The timer only runs once the executor is initialised; the WAIT_INIT cycle that
  // sees init_done rise still holds it, so the first expiry lands REF_PERIOD edges later.
  always_comb begin
    run       = init_done && state != S_WAIT_INIT;
    expire    = run && cnt == '0;
    issue_ref = run && state == S_IDLE && ref_pending;
    idle_free = run && state == S_IDLE && !ref_pending;
    gnt_wr    = idle_free && wr_req && (!rd_req || last_rd);
    gnt_rd    = idle_free && rd_req && !gnt_wr;
    state_nxt = !init_done ? S_WAIT_INIT :
                state == S_WAIT_INIT ? S_IDLE :
                state == S_IDLE ? (issue_ref ? S_REF : gnt_wr ? S_WR : gnt_rd ? S_RD : S_IDLE) :
                exec_done ? S_IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_WAIT_INIT;
    else state <= state_nxt;
  // An expiry coinciding with a refresh issue re-arms ref_pending instead of
  // counting as an overrun: the refresh just issued covers the old period.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt         <= RELOAD;
      ref_pending <= 1'b0;
      ref_overrun <= 1'b0;
      last_rd     <= 1'b1;
      wr_ack      <= 1'b0;
      rd_ack      <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_op      <= 2'b00;
      cmd_addr    <= '0;
      busy        <= 1'b0;
    end else begin
      cnt         <= (!run || expire) ? RELOAD : cnt - 11'd1;
      ref_pending <= run && (expire || (ref_pending && !issue_ref));
      ref_overrun <= ref_overrun || (expire && ref_pending && !issue_ref);
      last_rd     <= gnt_rd || (last_rd && !gnt_wr);
      wr_ack      <= gnt_wr;
      rd_ack      <= gnt_rd;
      cmd_valid   <= issue_ref || gnt_wr || gnt_rd;
      cmd_op      <= issue_ref ? 2'b01 : gnt_wr ? 2'b10 : gnt_rd ? 2'b11 : 2'b00;
      cmd_addr    <= gnt_wr ? wr_addr : gnt_rd ? rd_addr : '0;
      busy        <= state_nxt inside {S_REF, S_WR, S_RD};
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: scenario and randomized checks of sdram_arbiter against a behavioural model
module tb_sdram_arbiter;
  localparam int AW = 22;
  localparam int R  = 16;
  logic clk = 1'b0, rst_n = 1'b0, init_done = 1'b0, wr_req = 1'b0, rd_req = 1'b0, exec_done = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic wr_ack, rd_ack, cmd_valid, busy, ref_overrun;
  logic [1:0] cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [AW+6:0] dut_v, exp_v;
  int n_cmp = 0, n_err = 0;
  int edge_n, m_tinit, m_op;
  bit m_ready, m_pend, m_lastrd, m_over;
  int ex_cnt, ex_lat;
  bit ex_hold, wr_drop, rd_drop, rnd;

  sdram_arbiter #(.ADDR_W(AW), .REF_PERIOD(R)) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .exec_done(exec_done), .busy(busy), .ref_overrun(ref_overrun)
  );

  always #5 clk = ~clk;
  assign dut_v = {wr_ack, rd_ack, cmd_valid, cmd_op, cmd_addr, busy, ref_overrun};

  // Model: m_op is the operation in flight (0 none, 1 ref, 2 write, 3 read); refresh
  // deadlines fall on every R-th edge after the edge that saw init_done rise.
  task automatic model_update();
    logic wa, ra, cv, issued, expire;
    logic [1:0] op;
    logic [AW-1:0] ad;
    wa = 0; ra = 0; cv = 0; op = 2'b00; ad = '0; issued = 0;
    edge_n++;
    if (!init_done) begin
      m_ready = 0; m_op = 0; m_pend = 0;
    end else if (!m_ready) begin
      m_ready = 1; m_tinit = edge_n;
    end else begin
      expire = ((edge_n - m_tinit) % R) == 0;
      if (m_op == 0) begin
        if (m_pend) begin
          m_op = 1; issued = 1; cv = 1; op = 2'b01;
        end else if (wr_req && (!rd_req || m_lastrd)) begin
          m_op = 2; m_lastrd = 0; wa = 1; cv = 1; op = 2'b10; ad = wr_addr;
        end else if (rd_req) begin
          m_op = 3; m_lastrd = 1; ra = 1; cv = 1; op = 2'b11; ad = rd_addr;
        end
      end else if (exec_done) m_op = 0;
      if (expire) begin
        if (m_pend && !issued) m_over = 1;
        m_pend = 1;
      end else if (issued) m_pend = 0;
    end
    exp_v = {wa, ra, cv, op, ad, m_op != 0, m_over};
  endtask

  // Executor and requester behaviour reacting to what the DUT showed this cycle.
  task automatic auto_drive();
    exec_done = 0;
    if (cmd_valid) ex_cnt = rnd ? int'($urandom_range(6, 1)) : ex_lat;
    else if (ex_cnt > 0 && !ex_hold) begin
      ex_cnt--;
      exec_done = (ex_cnt == 0);
    end
    if (wr_ack && wr_drop) wr_req = 0;
    if (rd_ack && rd_drop) rd_req = 0;
    if (rnd) begin
      if (!wr_req || wr_ack) begin wr_req = ($urandom_range(2) == 0); wr_addr = AW'($urandom); end
      if (!rd_req || rd_ack) begin rd_req = ($urandom_range(2) == 0); rd_addr = AW'($urandom); end
      if (ex_cnt == 0 && $urandom_range(19) == 0) exec_done = 1;
      if (init_done ? $urandom_range(149) == 0 : $urandom_range(3) == 0) init_done = !init_done;
    end
  endtask

  task automatic cycle();
    model_update();
    @(negedge clk);
    auto_drive();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; init_done = 0; wr_req = 0; rd_req = 0; exec_done = 0; wr_addr = '0; rd_addr = '0;
    ex_cnt = 0; ex_lat = 3; ex_hold = 0; wr_drop = 0; rd_drop = 0; rnd = 0;
    edge_n = 0; m_tinit = 0; m_op = 0; m_ready = 0; m_pend = 0; m_lastrd = 1; m_over = 0;
    exp_v = '0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (dut_v !== exp_v) begin n_err++; $display("FAIL reset_values: dut=%h model=%h", dut_v, exp_v); end
    wr_req = 1;
    repeat (50) begin
      cycle();
      n_cmp++;
      if (dut_v !== exp_v) begin n_err++; $display("FAIL reset_no_init edge %0d: dut=%h model=%h", edge_n, dut_v, exp_v); end
    end
  endtask

  task automatic test_write();
    int saw = 0;
    do_reset();
    init_done = 1;
    cycle();
    wr_req = 1; wr_addr = 22'h12345; wr_drop = 1; ex_lat = 20;
    repeat (30) begin
      cycle();
      n_cmp++;
      if (dut_v !== exp_v) begin n_err++; $display("FAIL write edge %0d: dut=%h model=%h", edge_n, dut_v, exp_v); end
      if (wr_ack) begin
        saw++;
        n_cmp++;
        if (!cmd_valid || cmd_op !== 2'b10 || cmd_addr !== 22'h12345) begin
          n_err++; $display("FAIL write_cmd: valid=%b op=%b addr=%h want 1/10/12345", cmd_valid, cmd_op, cmd_addr);
        end
      end
    end
    n_cmp++;
    if (saw != 1) begin n_err++; $display("FAIL write_ack_count: got %0d want 1", saw); end
  endtask

  task automatic test_alternate();
    bit want_rd = 0;
    int grants = 0;
    do_reset();
    init_done = 1;
    cycle();
    wr_req = 1; rd_req = 1; wr_addr = 22'h0AAAA; rd_addr = 22'h15555; ex_lat = 5;
    repeat (100) begin
      cycle();
      n_cmp++;
      if (dut_v !== exp_v) begin n_err++; $display("FAIL alternate edge %0d: dut=%h model=%h", edge_n, dut_v, exp_v); end
      if (wr_ack || rd_ack) begin
        n_cmp++;
        if ((wr_ack && rd_ack) || rd_ack !== want_rd) begin
          n_err++; $display("FAIL alternate_order: wr_ack=%b rd_ack=%b want rd=%b", wr_ack, rd_ack, want_rd);
        end
        want_rd = !want_rd;
        grants++;
      end
    end
    n_cmp++;
    if (grants < 8) begin n_err++; $display("FAIL alternate_progress: %0d grants want >=8", grants); end
  endtask

  task automatic test_refresh_idle();
    int last = -1, nref = 0;
    do_reset();
    init_done = 1; ex_lat = 3;
    repeat (80) begin
      cycle();
      n_cmp++;
      if (dut_v !== exp_v) begin n_err++; $display("FAIL refresh edge %0d: dut=%h model=%h", edge_n, dut_v, exp_v); end
      if (cmd_valid) begin
        n_cmp++;
        if (cmd_op !== 2'b01 || (last >= 0 && edge_n - last != R)) begin
          n_err++; $display("FAIL refresh_spacing: op=%b gap=%0d want 01/%0d", cmd_op, edge_n - last, R);
        end
        last = edge_n;
        nref++;
      end
    end
    n_cmp++;
    if (nref != 4 || ref_overrun !== 1'b0) begin
      n_err++; $display("FAIL refresh_count: %0d refreshes overrun=%b want 4/0", nref, ref_overrun);
    end
  endtask

  task automatic test_overrun();
    logic [1:0] ops [2];
    int k = 0;
    do_reset();
    init_done = 1;
    cycle();
    wr_req = 1; wr_addr = 22'h2F00D; wr_drop = 1; ex_hold = 1; ex_lat = 1;
    repeat (40) begin
      cycle();
      if (edge_n == 5) begin rd_req = 1; rd_addr = 22'h3BEEF; rd_drop = 1; end
      n_cmp++;
      if (dut_v !== exp_v) begin n_err++; $display("FAIL overrun_hold edge %0d: dut=%h model=%h", edge_n, dut_v, exp_v); end
    end
    n_cmp++;
    if (ref_overrun !== 1'b1) begin n_err++; $display("FAIL overrun_flag: got %b want 1", ref_overrun); end
    ex_hold = 0;
    repeat (20) begin
      cycle();
      n_cmp++;
      if (dut_v !== exp_v) begin n_err++; $display("FAIL overrun_after edge %0d: dut=%h model=%h", edge_n, dut_v, exp_v); end
      if (cmd_valid && k < 2) begin ops[k] = cmd_op; k++; end
    end
    n_cmp++;
    if (k != 2 || ops[0] !== 2'b01 || ops[1] !== 2'b11) begin
      n_err++; $display("FAIL overrun_order: %0d ops first=%b second=%b want 01 then 11", k, ops[0], ops[1]);
    end
  endtask

  task automatic test_init_drop();
    int waited = 0, saw = 0;
    do_reset();
    init_done = 1;
    cycle();
    rd_req = 1; rd_addr = 22'h1C0DE; rd_drop = 1; ex_lat = 10;
    while (!rd_ack && waited < 20) begin
      cycle();
      waited++;
      n_cmp++;
      if (dut_v !== exp_v) begin n_err++; $display("FAIL drop_grant edge %0d: dut=%h model=%h", edge_n, dut_v, exp_v); end
    end
    n_cmp++;
    if (!rd_ack) begin n_err++; $display("FAIL drop_grant_timeout: rd_ack=%b after %0d cycles want 1", rd_ack, waited); end
    repeat (2) cycle();
    init_done = 0;
    cycle();
    n_cmp++;
    if (busy !== 1'b0 || dut_v !== exp_v) begin n_err++; $display("FAIL drop_busy: busy=%b dut=%h model=%h", busy, dut_v, exp_v); end
    repeat (15) begin
      cycle();
      n_cmp++;
      if (cmd_valid || busy || dut_v !== exp_v) begin n_err++; $display("FAIL drop_idle edge %0d: dut=%h model=%h", edge_n, dut_v, exp_v); end
    end
    init_done = 1; wr_req = 1; wr_addr = 22'h00ABC; wr_drop = 1; ex_lat = 4;
    repeat (10) begin
      cycle();
      n_cmp++;
      if (dut_v !== exp_v) begin n_err++; $display("FAIL drop_resume edge %0d: dut=%h model=%h", edge_n, dut_v, exp_v); end
      if (wr_ack && cmd_addr === 22'h00ABC) saw++;
    end
    n_cmp++;
    if (saw != 1) begin n_err++; $display("FAIL drop_resume_grant: %0d write grants want 1", saw); end
  endtask

  task automatic test_random();
    do_reset();
    rnd = 1; init_done = 1;
    repeat (3000) begin
      cycle();
      n_cmp++;
      if (dut_v !== exp_v) begin n_err++; $display("FAIL random edge %0d: dut=%h model=%h", edge_n, dut_v, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_alternate();
    test_refresh_idle();
    test_overrun();
    test_init_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
